rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (we/waddr/wdata, gated downstream by stallW) between NREQ writeback sources: in-order pipeline WB, multi-cycle divider, and late load return.
- Arbitrates round-robin and registers the winner in a one-deep output stage that drives the register file.
- Holds the staged write while writeback is stalled, and counts arbitration conflicts for performance analysis.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 5, register address width
DW, 32, register data width
CW, 16, conflict counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stallW  in  1  writeback stall; the register file does not write while high
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester accept
req_addr  in  NREQ*AW  destination register, requester i at [i*AW +: AW]
req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
rf_we  out  1  register file write enable (registered)
rf_waddr  out  AW  register file write address (registered)
rf_wdata  out  DW  register file write data (registered)
conflict_cnt  out  CW  saturating count of contended cycles
grant_idx  out  3  index of the last accepted requester (debug)

Behaviour:
- Reset (rst=0, async):
  - rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, grant_idx=0, RR pointer ptr=0.
  - req_ready=0 while in reset.
  - Any staged write is discarded; the first request after reset release is arbitrated from ptr=0.
- Arbitration (combinational):
  - Scan req_valid from ptr upward, modulo NREQ; the first valid index is winner w.
  - req_ready[w]=~stallW. All other req_ready bits=0.
  - No valid requests: req_ready=0.
- Transfer: req_valid[i] & req_ready[i].
  - Requester rule: once req_valid is raised, addr and data stay stable and valid stays high until the transfer.
- Output stage, per cycle:
  - stallW=1: rf_we/rf_waddr/rf_wdata hold. No transfer occurs, and ptr and grant_idx hold.
  - stallW=0 with a transfer from w: rf_waddr<=req_addr[w], rf_wdata<=req_data[w], rf_we<=(req_addr[w]!=0), grant_idx<=w, ptr<=(w+1) mod NREQ.
  - stallW=0 without a transfer: rf_we<=0; waddr/wdata hold; ptr holds.
- Latency:
  - Accepted in cycle T, the request appears on rf_* in cycle T+1 and is written at the end of the first cycle ≥T+1 in which stallW=0.
  - Sustained throughput is 1 write/cycle when unstalled.
- Writes to r0 are accepted (ready asserted, pointer advances) but never produce rf_we=1.
- Stall release: in the cycle stallW falls, the held write commits and a new transfer is accepted in the same cycle, so no bubble is needed.
- Fairness: a continuously valid requester is granted within NREQ unstalled cycles.
- conflict_cnt:
  - Increments by 1 in each cycle with stallW=0 and two or more req_valid bits set.
  - Saturates at 2^CW-1 and does not wrap.
- Same address from two requesters: they are serialised in grant order, so the last granted value persists.

Optional Feature:
- Macro: RF_WB_PRIO0_EN.
- Defined: requester 0 (in-order pipeline WB) has fixed highest priority. Whenever req_valid[0]=1 it wins regardless of ptr, and ptr does not change on a requester-0 grant. The remaining requesters stay round-robin among themselves.
- Undefined: pure round-robin across all NREQ requesters, as above.

Test Plan:
- Reset then single request i=1, addr=5, data=0xDEADBEEF, stallW=0 -> ready[1]=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_idx=1; following cycle rf_we=0.
- All 3 valid continuously for 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2; conflict_cnt=6 (PRIO0 undefined). With RF_WB_PRIO0_EN, the same stimulus -> requester 0 granted every cycle, conflict_cnt=6.
- Accept addr=7/data=0x11, then stallW=1 for 3 cycles with req 2 valid -> rf_* hold 7/0x11 with rf_we=1, ready=0; on stall release, req 2 is accepted in the same cycle and appears on rf_* the next cycle.
- Request addr=0, data=0xFFFFFFFF -> ready asserted, ptr advances, rf_we stays 0.
- Assert rst=0 asynchronously mid-stream with rf_we=1 -> all outputs 0 immediately without a clock edge; after release, the first grant goes to the lowest valid index.
- Force contention for 2^CW+5 cycles (CW=4 build) -> conflict_cnt saturates at 15.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port.
// Optional fixed priority for requester 0 under `RF_WB_PRIO0_EN.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallW,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [CW-1:0]     conflict_cnt,
  output logic [2:0]        grant_idx
);

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      gidx_q, gidx_d;
  logic [2:0]      ptr_q, ptr_d;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   win_oh;
  logic [3:0]        sum;
  logic [2:0]        win;
  logic [2:0]        win_nxt;
  logic              any_vld;
  logic              xfer;
  logic              multi;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;

  // Rotate requests so the scan starts at ptr; first hit is the winner.
  always_comb begin
    dbl     = {req_valid, req_valid};
    rot     = NREQ'(dbl >> ptr_q);
    win     = 3'd0;
    any_vld = 1'b0;
    sum     = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_vld && rot[k]) begin
        any_vld = 1'b1;
        sum     = {1'b0, ptr_q} + 4'(k);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        win     = sum[2:0];
      end
    end
`ifdef RF_WB_PRIO0_EN
    if (req_valid[0]) begin
      any_vld = 1'b1;
      win     = 3'd0;
    end
`endif
  end

  // Grant decode, data select and conflict detection.
  always_comb begin
    win_oh   = NREQ'(1) << win;
    xfer     = any_vld & ~stallW;
    req_ready = (rst && xfer) ? win_oh : '0;
    multi    = |(req_valid & (req_valid - NREQ'(1)));
    win_nxt  = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_oh[k]) begin
        sel_addr = req_addr[k*AW +: AW];
        sel_data = req_data[k*DW +: DW];
      end
    end
  end

  // Next state of the output stage, pointer and conflict counter.
  always_comb begin
    rf_we_d = rf_we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!stallW) begin
      if (xfer) begin
        rf_we_d = |sel_addr;
        waddr_d = sel_addr;
        wdata_d = sel_data;
        gidx_d  = win;
`ifdef RF_WB_PRIO0_EN
        if (win != 3'd0) ptr_d = win_nxt;
`else
        ptr_d   = win_nxt;
`endif
      end else begin
        rf_we_d = 1'b0;
      end
      if (multi && !(&cnt_q)) cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any staged write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      gidx_q  <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign grant_idx    = gidx_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter.
// Directed vectors; monitor pops expected writes as they stage.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallW;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [CW-1:0]     conflict_cnt;
  logic [2:0]        grant_idx;

  logic [AW-1:0] a_arr [NREQ];
  logic [DW-1:0] d_arr [NREQ];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    g;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .stallW(stallW),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*AW +: AW] = a_arr[k];
      req_data[k*DW +: DW] = d_arr[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input int i);
    exp_t e;
    e.a = a_arr[i];
    e.d = d_arr[i];
    e.g = 3'(i);
    return e;
  endfunction

  function automatic int rr(input int k);
`ifdef RF_WB_PRIO0_EN
    return 0;
`else
    return k % NREQ;
`endif
  endfunction

  task automatic restore();
    a_arr[0] = 5'd10; d_arr[0] = 32'hA0A0_0000;
    a_arr[1] = 5'd11; d_arr[1] = 32'hB1B1_1111;
    a_arr[2] = 5'd12; d_arr[2] = 32'hC2C2_2222;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    stallW = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every newly staged write must match the queue head.
  initial begin
    logic st;
    logic r;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stallW;
      r  = rst;
      #1;
      if (r && !st && rf_we) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got %0h/%0h/%0d expected none",
                   rf_waddr, rf_wdata, grant_idx);
        end else begin
          e = q.pop_front();
          chk("wb_write", {rf_waddr, rf_wdata, grant_idx}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    stallW = 1'b0;
    req_valid = '0;
    restore();
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_gidx", grant_idx, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // single request
    a_arr[1] = 5'd5;
    d_arr[1] = 32'hDEAD_BEEF;
    req_valid = 3'b010;
    #1;
    chk("t1_ready", req_ready, 3'b010);
    q.push_back(ex(1));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_gidx", grant_idx, 1);
    @(negedge clk);
    #1;
    chk("t1_we_drop", rf_we, 0);
    restore();

    // full contention, six cycles
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 6; k++) q.push_back(ex(rr(k)));
    repeat (6) @(negedge clk);
    req_valid = '0;
    #1;
    chk("t2_conflict", conflict_cnt, 6);

    // stall hold and release
    a_arr[0] = 5'd7;
    d_arr[0] = 32'h11;
    req_valid = 3'b001;
    q.push_back(ex(0));
    @(negedge clk);
    a_arr[2] = 5'd9;
    d_arr[2] = 32'h22;
    req_valid = 3'b100;
    stallW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_we", rf_we, 1);
      chk("t3_hold_addr", rf_waddr, 7);
      chk("t3_hold_data", rf_wdata, 32'h11);
      chk("t3_stall_ready", req_ready, 0);
      @(negedge clk);
    end
    stallW = 1'b0;
    #1;
    chk("t3_release_ready", req_ready, 3'b100);
    chk("t3_release_we", rf_we, 1);
    q.push_back(ex(2));
    @(negedge clk);
    req_valid = '0;
    restore();

    // write to r0
    a_arr[1] = 5'd0;
    d_arr[1] = 32'hFFFF_FFFF;
    req_valid = 3'b010;
    #1;
    chk("t4_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t4_we", rf_we, 0);
    chk("t4_gidx", grant_idx, 1);
    restore();
    req_valid = 3'b101;
    #1;
`ifdef RF_WB_PRIO0_EN
    chk("t4_ptr", req_ready, 3'b001);
    q.push_back(ex(0));
`else
    chk("t4_ptr", req_ready, 3'b100);
    q.push_back(ex(2));
`endif
    @(negedge clk);
    req_valid = '0;

    // async reset mid-stream
    req_valid = 3'b010;
    q.push_back(ex(1));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_we_before", rf_we, 1);
    #1;
    rst = 1'b0;
    req_valid = 3'b110;
    #1;
    chk("t5_we", rf_we, 0);
    chk("t5_waddr", rf_waddr, 0);
    chk("t5_wdata", rf_wdata, 0);
    chk("t5_gidx", grant_idx, 0);
    chk("t5_cnt", conflict_cnt, 0);
    chk("t5_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_first_grant", req_ready, 3'b010);
    q.push_back(ex(1));
    q.push_back(ex(2));
    @(negedge clk);
    req_valid = 3'b100;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_cnt_after", conflict_cnt, 1);

    // counter saturation
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 21; k++) q.push_back(ex(rr(k)));
    repeat (21) @(negedge clk);
    req_valid = '0;
    #1;
    chk("t6_saturate", conflict_cnt, 15);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
